fp_round_pack_stage: RTL

- Final pipeline stage of the FP datapath, directly downstream of normalization. Consumes a normalized sign/exponent/23-bit mantissa with guard/round/sticky bits.
- Rounds per the `fp_pkg` rounding mode, then resolves mantissa carry-out into the exponent and detects overflow and underflow.
- Packs an IEEE-754 single-precision result with RISC-V-ordered exception flags.
- Two-register pipeline with valid/ready handshakes on both sides.

---
 rtl/fp_round_pack_stage_if.sv | 33 +++
 rtl/fp_round_pack_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fp_round_pack_stage_if.sv
// Handshake and data bundle for the FP round/pack stage.
// Master drives operands and out_ready; slave is the stage itself.
interface fp_round_pack_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [22:0] in_mantissa;
    logic        in_guard;
    logic        in_round;
    logic        in_sticky;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic [1:0]  in_exc;
    logic [2:0]  rounding_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mantissa, in_guard, in_round, in_sticky,
               in_is_nan, in_is_inf, in_is_zero, in_exc, rounding_mode, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mantissa, in_guard, in_round, in_sticky,
               in_is_nan, in_is_inf, in_is_zero, in_exc, rounding_mode, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_round_pack_stage.sv
// Final FP stage: round, resolve carry/overflow, pack IEEE-754 single with {NV,DZ,OF,UF,NX}.
// Optional sticky flag accumulator enabled by macro FP_FLAGS_STICKY_EN.
module fp_round_pack_stage #(
    parameter int unsigned MAX_EXP   = 255,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_round_pack_stage_if.slave bus,
    input  logic                 flags_clear,
    output logic [4:0]           acc_flags
);
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    logic        s1_valid, s2_valid, s1_load, s2_load;
    logic [23:0] s1_sum;
    logic        s1_sign, s1_inexact, s1_nan, s1_inf, s1_zero;
    logic [9:0]  s1_exp;
    logic [1:0]  s1_exc;
    rm_e         s1_mode;
    logic [31:0] s2_result;
    logic [4:0]  s2_flags;

    rm_e         in_mode;
    logic        inexact, round_up;

    always_comb begin
        in_mode  = rm_e'(bus.rounding_mode);
        inexact  = bus.in_guard | bus.in_round | bus.in_sticky;
        round_up = 1'b0;
        case (in_mode)
            RM_RNE:  round_up = bus.in_guard & (bus.in_round | bus.in_sticky | bus.in_mantissa[0]);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = bus.in_sign & inexact;
            RM_RUP:  round_up = ~bus.in_sign & inexact;
            RM_RMM:  round_up = bus.in_guard;
            default: round_up = 1'b0;
        endcase
    end

    assign s2_load        = ~s2_valid | bus.out_ready;
    assign bus.in_ready   = ~s1_valid | s2_load;
    assign s1_load        = bus.in_valid & bus.in_ready;
    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.out_flags  = s2_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
        end
    end

    // Mode is registered with its operand so later mode changes never touch it.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_sum     <= {1'b0, bus.in_mantissa} + {23'd0, round_up};
            s1_sign    <= bus.in_sign;
            s1_exp     <= bus.in_exp;
            s1_inexact <= inexact;
            s1_nan     <= bus.in_is_nan;
            s1_inf     <= bus.in_is_inf;
            s1_zero    <= bus.in_is_zero;
            s1_exc     <= bus.in_exc;
            s1_mode    <= in_mode;
        end
    end

    logic [10:0] exp_r;
    logic [22:0] frac;
    logic        ovf, ovf_to_inf;
    logic [31:0] pack_result;
    logic [4:0]  pack_flags;

    // Exponent widened to 11 bits so the overflow compare cannot wrap.
    always_comb begin
        exp_r = {1'b0, s1_exp} + {10'd0, s1_sum[23]};
        frac  = s1_sum[23] ? '0 : s1_sum[22:0];
        ovf   = exp_r >= 11'(MAX_EXP);
        case (s1_mode)
            RM_RNE, RM_RMM: ovf_to_inf = 1'b1;
            RM_RDN:         ovf_to_inf = s1_sign;
            RM_RUP:         ovf_to_inf = ~s1_sign;
            default:        ovf_to_inf = 1'b0;
        endcase
        pack_flags = {s1_exc, 3'b000};
        if (s1_nan) begin
            pack_result = CANON_NAN;
        end else if (s1_inf) begin
            pack_result = {s1_sign, 8'hFF, 23'd0};
        end else if (s1_zero) begin
            pack_result = {s1_sign, 31'd0};
        end else begin
            pack_flags[2] = ovf;
            pack_flags[1] = (s1_exp == 10'd0) & s1_inexact;
            pack_flags[0] = s1_inexact | ovf;
            if (ovf) begin
                pack_result = ovf_to_inf ? {s1_sign, 8'hFF, 23'd0} : {s1_sign, 31'h7F7FFFFF};
            end else begin
                pack_result = {s1_sign, exp_r[7:0], frac};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= pack_result;
                s2_flags  <= pack_flags;
            end
        end
    end

`ifdef FP_FLAGS_STICKY_EN
    logic out_xfer;
    assign out_xfer = s2_valid & bus.out_ready;

    // A clear coinciding with a transfer keeps only that transfer's flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_flags <= '0;
        end else if (flags_clear) begin
            acc_flags <= out_xfer ? s2_flags : '0;
        end else if (out_xfer) begin
            acc_flags <= acc_flags | s2_flags;
        end
    end
`else
    logic unused_flags_clear;
    assign unused_flags_clear = flags_clear;
    assign acc_flags          = '0;
`endif

endmodule
